// File: rtl/expu_pkg.sv
// rtl/expu_pkg.sv - shared types and constants for the exp-unit scale/split stage
package expu_pkg;

    localparam int BF16_BIAS = 127;
    // |x| >= 2^E_SAT always leaves the finite BF16 range, so no shift is attempted
    localparam int E_SAT = 7;
    localparam logic [32:0] LOG2E_Q32 = 33'h1_7154_7652;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] mant;
    } bf16_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } op_class_t;

    function automatic logic [32:0] log2e_const(input int frac);
        return LOG2E_Q32 >> (32 - frac);
    endfunction

endpackage

// File: rtl/expu_pipe_stage.sv
// rtl/expu_pipe_stage.sv - one elastic register slice with valid/ready and flush
module expu_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign ready_o = ~r_valid | ready_i;
    assign valid_o = r_valid;
    assign data_o  = r_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (clear_i) begin
            r_valid <= 1'b0;
        end else if (ready_o) begin
            r_valid <= valid_i;
            if (valid_i) begin
                r_data <= data_i;
            end
        end
    end

endmodule

// File: rtl/expu_scale_split.sv
// rtl/expu_scale_split.sv - y = x*log2(e) split into biased exponent and fraction
module expu_scale_split
    import expu_pkg::*;
#(
    parameter int FRACTION       = 7,
    parameter int LOG2E_FRACTION = 8,
    parameter int EXP_BITS       = 8,
    parameter int MANT_BITS      = 7
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [EXP_BITS+MANT_BITS:0]   op_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [EXP_BITS-1:0]           exponent_o,
    output logic [FRACTION-1:0]           mantissa_o,
    output logic                          underflow_o,
    output logic                          overflow_o,
    output logic                          nan_o
);

    localparam int OP_W  = 1 + EXP_BITS + MANT_BITS;
    localparam int SIG_W = MANT_BITS + 1;
    localparam int L_W   = LOG2E_FRACTION + 1;
    localparam int P_W   = SIG_W + L_W;
    localparam int E_W   = EXP_BITS + 1;
    localparam int SH_W  = E_W + 1;
    localparam int MAG_W = P_W + E_SAT;
    localparam int V_W   = MAG_W + 1;
    localparam int S1_W  = P_W + 1 + E_W + 2;
    localparam int S2_W  = EXP_BITS + FRACTION + 3;
    // P carries MANT_BITS+LOG2E_FRACTION fraction bits; this is the shift down to FRACTION
    localparam int RSH   = MANT_BITS + LOG2E_FRACTION - FRACTION;

    localparam logic [L_W-1:0]        LOG2E     = L_W'(log2e_const(LOG2E_FRACTION));
    localparam logic signed [E_W-1:0] E_SAT_S   = E_W'(E_SAT);
    localparam logic signed [V_W-1:0] BIAS_S    = V_W'(BF16_BIAS);
    localparam logic signed [V_W-1:0] EXP_MAX_S = V_W'((1 << EXP_BITS) - 1);

    logic                 w_sign;
    logic [EXP_BITS-1:0]  w_exp;
    logic [MANT_BITS-1:0] w_mant;
    logic [P_W-1:0]       w_p;
    logic [E_W-1:0]       w_e;
    op_class_t            w_cls;
    logic [S1_W-1:0]      w_s1_in;
    logic [S1_W-1:0]      w_s1_data;
    logic                 w_v1;
    logic                 w_s2_ready;

    assign w_sign = op_i[OP_W-1];
    assign w_exp  = op_i[OP_W-2:MANT_BITS];
    assign w_mant = op_i[MANT_BITS-1:0];

    always_comb begin
        w_cls = CLS_NORMAL;
        w_p   = P_W'({1'b1, w_mant}) * P_W'(LOG2E);
        w_e   = {1'b0, w_exp} - E_W'(BF16_BIAS);
        if (w_exp == '0) begin
            w_cls = CLS_ZERO;
            w_p   = '0;
            w_e   = '0;
        end else if (&w_exp) begin
            w_cls = (|w_mant) ? CLS_NAN : CLS_INF;
        end
    end

    assign w_s1_in = {w_p, w_sign, w_e, w_cls};

    expu_pipe_stage #(.W(S1_W)) u_stage1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (w_s1_in),
        .valid_o (w_v1),
        .ready_i (w_s2_ready),
        .data_o  (w_s1_data)
    );

    logic [P_W-1:0]          w_s1_p;
    logic                    w_s1_sign;
    logic signed [E_W-1:0]   w_s1_e;
    op_class_t               w_s1_cls;
    logic [SH_W-1:0]         w_shamt;
    logic [SH_W-1:0]         w_neg_sh;
    logic [MAG_W-1:0]        w_mag;
    logic signed [V_W-1:0]   w_val;
    logic signed [V_W-1:0]   w_floor;
    logic signed [V_W-1:0]   w_biased;
    logic [EXP_BITS-1:0]     w_exp_o;
    logic [FRACTION-1:0]     w_mant_o;
    logic                    w_un;
    logic                    w_ov;
    logic                    w_nan;
    logic [S2_W-1:0]         w_s2_data;

    assign w_s1_p    = w_s1_data[S1_W-1 -: P_W];
    assign w_s1_sign = w_s1_data[E_W+2];
    assign w_s1_e    = w_s1_data[E_W+1:2];
    assign w_s1_cls  = op_class_t'(w_s1_data[1:0]);

    always_comb begin
        w_shamt  = {w_s1_e[E_W-1], w_s1_e} - SH_W'(RSH);
        w_neg_sh = -w_shamt;
        if (w_shamt[SH_W-1]) begin
            w_mag = MAG_W'(w_s1_p) >> w_neg_sh;
        end else begin
            w_mag = MAG_W'(w_s1_p) << w_shamt;
        end
        w_val    = w_s1_sign ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
        w_floor  = w_val >>> FRACTION;
        w_biased = w_floor + BIAS_S;
    end

    always_comb begin
        w_exp_o  = '0;
        w_mant_o = '0;
        w_un     = 1'b0;
        w_ov     = 1'b0;
        w_nan    = 1'b0;
        case (w_s1_cls)
            CLS_ZERO: w_exp_o = EXP_BITS'(BF16_BIAS);
            CLS_NAN:  w_nan   = 1'b1;
            CLS_INF: begin
                w_un = w_s1_sign;
                w_ov = ~w_s1_sign;
            end
            default: begin
                if (w_s1_e >= E_SAT_S) begin
                    w_un = w_s1_sign;
                    w_ov = ~w_s1_sign;
                end else if (w_biased >= EXP_MAX_S) begin
                    w_ov = 1'b1;
                end else if (w_biased[V_W-1] || (w_biased == '0)) begin
                    w_un = 1'b1;
                end else begin
                    w_exp_o  = w_biased[EXP_BITS-1:0];
                    w_mant_o = w_val[FRACTION-1:0];
                end
            end
        endcase
    end

    expu_pipe_stage #(.W(S2_W)) u_stage2 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .valid_i (w_v1),
        .ready_o (w_s2_ready),
        .data_i  ({w_exp_o, w_mant_o, w_un, w_ov, w_nan}),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (w_s2_data)
    );

    assign {exponent_o, mantissa_o, underflow_o, overflow_o, nan_o} = w_s2_data;

endmodule

// File: tb/tb_expu_scale_split.sv
// tb/tb_expu_scale_split.sv - scoreboard bench for expu_scale_split
module tb_expu_scale_split;

    logic        clk;
    logic        rst_i;
    logic        clear_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] op_i;
    logic        valid_o;
    logic        ready_i;
    logic [7:0]  exponent_o;
    logic [6:0]  mantissa_o;
    logic        underflow_o;
    logic        overflow_o;
    logic        nan_o;

    expu_scale_split dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .op_i        (op_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .exponent_o  (exponent_o),
        .mantissa_o  (mantissa_o),
        .underflow_o (underflow_o),
        .overflow_o  (overflow_o),
        .nan_o       (nan_o)
    );

    typedef struct {
        logic [15:0] op;
        logic [7:0]  ex;
        logic [6:0]  ma;
        logic        un;
        logic        ov;
        logic        na;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    int    checks = 0;
    int    failures = 0;
    int    inflight = 0;
    bit    have_stall = 0;
    bit    rand_rdy = 0;
    logic [17:0] stall_snap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [15:0] op, input logic [7:0] ex, input logic [6:0] ma,
                                input logic un, input logic ov, input logic na);
        exp_t r;
        r.op = op; r.ex = ex; r.ma = ma; r.un = un; r.ov = ov; r.na = na;
        return r;
    endfunction

    // y = x*1.01110001b, magnitude truncated to 1/128, then split into floor and fraction
    function automatic exp_t model(input logic [15:0] op);
        exp_t   r;
        int     s, e, m, sh;
        longint p, mag, v, fl, fr, b;
        r = mk(op, 8'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        s = int'(op[15]);
        e = int'(op[14:7]);
        m = int'(op[6:0]);
        if (e == 255) begin
            if (m != 0) r.na = 1'b1;
            else if (s != 0) r.un = 1'b1;
            else r.ov = 1'b1;
            return r;
        end
        if (e == 0) begin
            r.ex = 8'd127;
            return r;
        end
        if (e - 127 >= 7) begin
            if (s != 0) r.un = 1'b1; else r.ov = 1'b1;
            return r;
        end
        p   = longint'(128 + m) * 369;
        sh  = 8 - (e - 127);
        mag = (sh > 62) ? 0 : (p >> sh);
        v   = (s != 0) ? -mag : mag;
        fl  = (v >= 0) ? v / 128 : -((-v + 127) / 128);
        fr  = v - fl * 128;
        b   = 127 + fl;
        if (b >= 255) r.ov = 1'b1;
        else if (b <= 0) r.un = 1'b1;
        else begin
            r.ex = 8'(b);
            r.ma = 7'(fr);
        end
        return r;
    endfunction

    task automatic fail_line(input string name, input logic [31:0] got, input logic [31:0] want);
        failures++;
        $display("FAIL %s got=%0h expected=%0h", name, got, want);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) fail_line(name, got, want);
    endtask

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [15:0] op, input exp_t e);
        int n = 0;
        valid_i = 1'b1;
        op_i    = op;
        @(negedge clk);
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            checks++;
            fail_line("send_timeout", 32'(op), 32'h0);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_i || clear_i) begin
            exp_q.delete();
            inflight   = 0;
            have_stall = 0;
        end else begin
            checks++;
            if (ready_o !== ((inflight < 2) || ready_i))
                fail_line("ready_o", 32'(ready_o), 32'((inflight < 2) || ready_i));
            if (valid_o && !ready_i) begin
                if (have_stall) begin
                    checks++;
                    if ({exponent_o, mantissa_o, underflow_o, overflow_o, nan_o} !== stall_snap)
                        fail_line("stall_hold", 32'({exponent_o, mantissa_o, underflow_o, overflow_o, nan_o}),
                                  32'(stall_snap));
                end
                stall_snap = {exponent_o, mantissa_o, underflow_o, overflow_o, nan_o};
                have_stall = 1;
            end else begin
                have_stall = 0;
            end
            if (valid_o && ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fail_line("unexpected_output", 32'({exponent_o, mantissa_o}), 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({exponent_o, mantissa_o, underflow_o, overflow_o, nan_o} !==
                        {mon_e.ex, mon_e.ma, mon_e.un, mon_e.ov, mon_e.na}) begin
                        failures++;
                        $display("FAIL result op=%h got exp=%h man=%h un=%b ov=%b nan=%b expected exp=%h man=%h un=%b ov=%b nan=%b",
                                 mon_e.op, exponent_o, mantissa_o, underflow_o, overflow_o, nan_o,
                                 mon_e.ex, mon_e.ma, mon_e.un, mon_e.ov, mon_e.na);
                    end
                end
            end
            if (valid_i && ready_o) inflight++;
            if (valid_o && ready_i) inflight--;
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] dir_ops [0:14];
    exp_t        dir_exp [0:14];

    initial begin
        logic [15:0] op;
        rst_i = 1'b1; clear_i = 1'b0; valid_i = 1'b0; op_i = '0; ready_i = 1'b1;

        dir_ops[0]  = 16'hBF80; dir_exp[0]  = mk(16'hBF80, 8'h7D, 7'h48, 0, 0, 0);
        dir_ops[1]  = 16'h0000; dir_exp[1]  = mk(16'h0000, 8'h7F, 7'h00, 0, 0, 0);
        dir_ops[2]  = 16'h0001; dir_exp[2]  = mk(16'h0001, 8'h7F, 7'h00, 0, 0, 0);
        dir_ops[3]  = 16'h4300; dir_exp[3]  = mk(16'h4300, 8'h00, 7'h00, 0, 1, 0);
        dir_ops[4]  = 16'hC300; dir_exp[4]  = mk(16'hC300, 8'h00, 7'h00, 1, 0, 0);
        dir_ops[5]  = 16'h7FC0; dir_exp[5]  = mk(16'h7FC0, 8'h00, 7'h00, 0, 0, 1);
        dir_ops[6]  = 16'hFF80; dir_exp[6]  = mk(16'hFF80, 8'h00, 7'h00, 1, 0, 0);
        dir_ops[7]  = 16'h7F80; dir_exp[7]  = mk(16'h7F80, 8'h00, 7'h00, 0, 1, 0);
        dir_ops[8]  = 16'h42B2; dir_exp[8]  = mk(16'h42B2, 8'h00, 7'h00, 0, 1, 0);
        dir_ops[9]  = 16'h42B0; dir_exp[9]  = mk(16'h42B0, 8'hFD, 7'h6C, 0, 0, 0);
        dir_ops[10] = 16'hC2B0; dir_exp[10] = mk(16'hC2B0, 8'h00, 7'h00, 1, 0, 0);
        dir_ops[11] = 16'hC2AE; dir_exp[11] = mk(16'hC2AE, 8'h01, 7'h4D, 0, 0, 0);
        dir_ops[12] = 16'h3C00; dir_exp[12] = mk(16'h3C00, 8'h7F, 7'h01, 0, 0, 0);
        dir_ops[13] = 16'hBC00; dir_exp[13] = mk(16'hBC00, 8'h7E, 7'h7F, 0, 0, 0);
        dir_ops[14] = 16'hFFC1; dir_exp[14] = mk(16'hFFC1, 8'h00, 7'h00, 0, 0, 1);

        #12;
        check("reset_valid_o", 32'(valid_o), 32'd0);
        check("reset_ready_o", 32'(ready_o), 32'd1);
        check("reset_outputs", 32'({exponent_o, mantissa_o, underflow_o, overflow_o, nan_o}), 32'd0);
        @(posedge clk); #3; rst_i = 1'b0;
        @(posedge clk); #1;

        send(16'h3F80, mk(16'h3F80, 8'h80, 7'h38, 0, 0, 0));
        @(negedge clk);
        check("latency_not_early", 32'(valid_o), 32'd0);
        @(posedge clk); #1;
        check("latency_two", 32'(valid_o), 32'd1);
        drain();

        for (int i = 0; i < 15; i++) send(dir_ops[i], dir_exp[i]);
        drain();

        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    op = 16'($urandom);
                    op[14:7] = 8'($urandom_range(118, 133));
                    send(op, model(op));
                end
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!(valid_o && ready_i) && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("stall_first_out", 32'(valid_o && ready_i), 32'd1);
                @(posedge clk); #1; ready_i = 1'b0;
                repeat (3) @(posedge clk);
                #1; ready_i = 1'b1;
            end
        join
        drain();

        ready_i = 1'b0;
        send(16'h3F80, model(16'h3F80));
        send(16'h4000, model(16'h4000));
        @(negedge clk);
        check("full_valid_o", 32'(valid_o), 32'd1);
        check("full_ready_o", 32'(ready_o), 32'd0);
        @(posedge clk); #1; clear_i = 1'b1;
        @(posedge clk); #1; clear_i = 1'b0;
        @(negedge clk);
        check("clear_valid_o", 32'(valid_o), 32'd0);
        check("clear_ready_o", 32'(ready_o), 32'd1);
        @(posedge clk); #1;

        send(16'h3F80, model(16'h3F80));
        send(16'hC000, model(16'hC000));
        @(negedge clk);
        check("pre_rst_valid_o", 32'(valid_o), 32'd1);
        @(posedge clk); #3; rst_i = 1'b1;
        #1;
        check("async_rst_valid_o", 32'(valid_o), 32'd0);
        check("async_rst_outputs", 32'({exponent_o, mantissa_o, underflow_o, overflow_o, nan_o}), 32'd0);
        @(posedge clk); #3; rst_i = 1'b0;
        @(posedge clk); #1; ready_i = 1'b1;

        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            op = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       ;
                1:       op[14:7] = 8'($urandom_range(100, 140));
                default: op[14:7] = 8'($urandom_range(118, 134));
            endcase
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            send(op, model(op));
        end
        rand_rdy = 0;
        @(posedge clk); #2; ready_i = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/expu_scale_split.md
Name: expu_scale_split

Overview:
Upstream neighbour of the exp-unit mantissa correction stage. Accepts a BF16 operand x and computes y = x·log2(e) in fixed point. It splits y into a biased integer exponent and a FRACTION-bit fractional part; the fractional part feeds the correction stage's mantissa input. Two-stage elastic pipeline with valid/ready handshake; special cases (zero, NaN, inf, range overflow/underflow) are flagged here so downstream stages stay purely arithmetic.

Parameters:
FRACTION, 7, fraction bits of y delivered on mantissa_o (equals the correction stage's input fraction width)
LOG2E_FRACTION, 8, fraction bits of the log2(e) constant (1.01110001b at default)
EXP_BITS, 8, BF16 exponent width
MANT_BITS, 7, BF16 stored-mantissa width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
clear_i  in  1  synchronous flush of both pipeline stages
valid_i  in  1  input operand valid
ready_o  out  1  block can accept operand this cycle
op_i  in  1+EXP_BITS+MANT_BITS  BF16 operand {sign, exp, mant}
valid_o  out  1  result valid
ready_i  in  1  downstream accepts result
exponent_o  out  EXP_BITS  biased result exponent, 127+floor(y)
mantissa_o  out  FRACTION  y − floor(y), unsigned fraction
underflow_o  out  1  e^x below smallest normal; result must be +0
overflow_o  out  1  e^x above max finite; result must be +inf
nan_o  out  1  operand is NaN

Behaviour:
- Reset (rst_i high, async): both stage valids 0, valid_o=0, all data/flag outputs 0. Operand in flight mid-reset is dropped.
- Transfer on valid&ready at each interface. Latency 2 cycles input-to-valid_o with no stall; full throughput 1/cycle.
- Stage advance: S2 loads when S2 empty or ready_i; S1 loads when S1 empty or S1 advances. ready_o = ~v1 | ~v2 | ready_i. Outputs hold stable while valid_o & ~ready_i.
- clear_i: clears v1,v2 next edge; an input handshake in the same cycle is discarded. rst_i has priority over clear_i.
- Stage 1: decode. exp==0 (zero/denormal) → treat x=0. exp==all-ones & mant!=0 → nan. exp==all-ones & mant==0 → inf with sign. Compute P = {1,mant} × LOG2E (unsigned, 8×(1+LOG2E_FRACTION) bits); register P, sign, e−127, class.
- Stage 2: shift P by (e−127) and truncate magnitude to FRACTION fraction bits (truncation toward zero on magnitude); if sign, two's-complement negate. floor(y) = arithmetic upper bits; mantissa_o = low FRACTION bits.
- e−127 ≥ 7 (|x| ≥ 128): no shift; overflow_o if sign=0, else underflow_o.
- Right shifts beyond the product width yield magnitude 0.
- Range: 127+floor(y) ≥ 255 → overflow_o; ≤ 0 → underflow_o. Denormal outputs are not produced.
- When any flag is set: exponent_o=0 and mantissa_o=0. Flags are mutually exclusive. Zero input gives exponent_o=127, mantissa_o=0.
- +inf → overflow_o; −inf → underflow_o; NaN → nan_o, with the sign ignored.

Decomposition:
- expu_pkg holds: bf16_t packed struct, BF16_BIAS=127, LOG2E constant (parameterised by LOG2E_FRACTION), operand-class enum {ZERO, NORMAL, INF, NAN}.
- Sub-module expu_pipe_stage: one elastic register slice carrying valid, payload and clear. Instantiated twice with different payload widths.

Test Plan:
- 0x3F80 (1.0), ready_i=1 → 2 cycles later valid_o=1, exponent_o=0x80, mantissa_o=0x38, flags 0.
- 0xBF80 (−1.0) → exponent_o=0x7D (floor −2), mantissa_o=0x48.
- 0x0000 and 0x0001 (denormal) → exponent_o=0x7F, mantissa_o=0x00.
- Range and specials → exact flag, with exponent_o=0 and mantissa_o=0:
  - 0x4300 (+128) → overflow_o=1.
  - 0xC300 (−128) → underflow_o=1.
  - 0x7FC0 → nan_o=1.
  - 0xFF80 → underflow_o=1.
- Back-to-back 4 operands, ready_i low for 3 cycles after the first output:
  - ready_o drops after S1 and S2 fill.
  - No operand is lost or duplicated; outputs are held stable while stalled.
  - Order is preserved.
- Pipeline full, then disruption:
  - assert clear_i one cycle → valid_o=0 next cycle, and ready_o=1.
  - separately assert rst_i asynchronously mid-cycle → valid_o falls immediately.
